// File: rtl/vscale_htif_host_bridge.sv
`default_nettype none
// ============================================================================
// Module   : vscale_htif_host_bridge
// Brief    : Host-side HTIF PCR master. It polls to_host, streams nonzero
//            values to the host, and queues host from_host writes.
//            Optional counters are enabled by VSCALE_HTIF_STATS_EN.
// Revision : 1.0  initial release
// ============================================================================
module vscale_htif_host_bridge #(
    parameter int          POLL_INTERVAL  = 16,
    parameter int          FIFO_DEPTH     = 4,
    parameter logic [11:0] ADDR_TO_HOST   = 12'h780,
    parameter logic [11:0] ADDR_FROM_HOST = 12'h781
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fromhost_valid,
    output logic        fromhost_ready,
    input  logic [63:0] fromhost_data,
    output logic        tohost_valid,
    input  logic        tohost_ready,
    output logic [63:0] tohost_data,
    output logic        htif_pcr_req_valid,
    input  logic        htif_pcr_req_ready,
    output logic        htif_pcr_req_rw,
    output logic [11:0] htif_pcr_req_addr,
    output logic [63:0] htif_pcr_req_data,
    input  logic        htif_pcr_resp_valid,
    output logic        htif_pcr_resp_ready,
    input  logic [63:0] htif_pcr_resp_data,
    output logic        busy,
    output logic [15:0] stat_polls,
    output logic [15:0] stat_msgs
);

    localparam int                PTR_W         = $clog2(FIFO_DEPTH);
    localparam int                CNT_W         = $clog2(POLL_INTERVAL);
    localparam logic [CNT_W-1:0]  c_POLL_RELOAD = CNT_W'(POLL_INTERVAL - 1);
    localparam logic [PTR_W:0]    c_FIFO_FULL   = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_poll_cnt;
    logic               r_op_wr;
    logic [11:0]        r_addr;
    logic [63:0]        r_data;
    logic               r_tohost_valid;
    logic [63:0]        r_tohost_data;

    logic [63:0]        r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [PTR_W:0]     r_count;

    logic               w_push;
    logic               w_pop;
    logic               w_wr_cand;
    logic               w_poll_cand;
    logic               w_req_hs;
    logic               w_resp_hs;
    logic               w_msg_load;

    assign fromhost_ready = (r_count != c_FIFO_FULL);
    assign w_push         = fromhost_valid && fromhost_ready;
    assign w_req_hs       = (r_state == S_REQ) && htif_pcr_req_ready;
    assign w_resp_hs      = (r_state == S_RESP) && htif_pcr_resp_valid;
    assign w_pop          = w_req_hs && r_op_wr;
    assign w_wr_cand      = (r_state == S_IDLE) && (r_count != '0);
    // Reading to_host clears it, so never poll while a captured value waits.
    assign w_poll_cand    = (r_state == S_IDLE) && (r_poll_cnt == '0) && !r_tohost_valid;
    assign w_msg_load     = w_resp_hs && !r_op_wr && (htif_pcr_resp_data != 64'd0);

    assign tohost_valid   = r_tohost_valid;
    assign tohost_data    = r_tohost_data;

    always_comb begin
        w_state_nxt         = r_state;
        htif_pcr_req_valid  = 1'b0;
        htif_pcr_req_rw     = 1'b0;
        htif_pcr_req_addr   = 12'd0;
        htif_pcr_req_data   = 64'd0;
        htif_pcr_resp_ready = 1'b0;
        busy                = (r_state != S_IDLE);
        case (r_state)
            S_IDLE: begin
                if (w_wr_cand || w_poll_cand) begin
                    w_state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                htif_pcr_req_valid = 1'b1;
                htif_pcr_req_rw    = r_op_wr;
                htif_pcr_req_addr  = r_addr;
                htif_pcr_req_data  = r_data;
                if (htif_pcr_req_ready) begin
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                htif_pcr_resp_ready = 1'b1;
                if (htif_pcr_resp_valid) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_poll_cnt     <= c_POLL_RELOAD;
            r_op_wr        <= 1'b0;
            r_addr         <= 12'd0;
            r_data         <= 64'd0;
            r_tohost_valid <= 1'b0;
            r_tohost_data  <= 64'd0;
        end else begin
            r_state <= w_state_nxt;

            if (w_resp_hs) begin
                r_poll_cnt <= c_POLL_RELOAD;
            end else if ((r_state == S_IDLE) && (r_poll_cnt != '0)) begin
                r_poll_cnt <= r_poll_cnt - CNT_W'(1);
            end

            // Pending writes win over a due poll.
            if (w_wr_cand) begin
                r_op_wr <= 1'b1;
                r_addr  <= ADDR_FROM_HOST;
                r_data  <= r_mem[r_rd_ptr];
            end else if (w_poll_cand) begin
                r_op_wr <= 1'b0;
                r_addr  <= ADDR_TO_HOST;
                r_data  <= 64'd0;
            end

            if (w_msg_load) begin
                r_tohost_valid <= 1'b1;
                r_tohost_data  <= htif_pcr_resp_data;
            end else if (r_tohost_valid && tohost_ready) begin
                r_tohost_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= r_count + (PTR_W + 1)'(w_push) - (PTR_W + 1)'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= fromhost_data;
        end
    end

`ifdef VSCALE_HTIF_STATS_EN
    logic [15:0] r_stat_polls;
    logic [15:0] r_stat_msgs;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stat_polls <= 16'd0;
            r_stat_msgs  <= 16'd0;
        end else begin
            if (w_req_hs && !r_op_wr) begin
                r_stat_polls <= r_stat_polls + 16'd1;
            end
            if (w_msg_load) begin
                r_stat_msgs <= r_stat_msgs + 16'd1;
            end
        end
    end

    assign stat_polls = r_stat_polls;
    assign stat_msgs  = r_stat_msgs;
`else
    assign stat_polls = 16'd0;
    assign stat_msgs  = 16'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vscale_htif_host_bridge.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_vscale_htif_host_bridge
// Brief    : Self-checking bench with a CSR responder and a transaction model.
// Revision : 1.0  initial release
// ============================================================================
module tb_vscale_htif_host_bridge;

    localparam int POLL  = 16;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        fromhost_valid = 1'b0;
    logic        fromhost_ready;
    logic [63:0] fromhost_data = 64'd0;
    logic        tohost_valid;
    logic        tohost_ready = 1'b0;
    logic [63:0] tohost_data;
    logic        htif_pcr_req_valid;
    logic        htif_pcr_req_ready = 1'b0;
    logic        htif_pcr_req_rw;
    logic [11:0] htif_pcr_req_addr;
    logic [63:0] htif_pcr_req_data;
    logic        htif_pcr_resp_valid = 1'b0;
    logic        htif_pcr_resp_ready;
    logic [63:0] htif_pcr_resp_data = 64'd0;
    logic        busy;
    logic [15:0] stat_polls;
    logic [15:0] stat_msgs;

    always #5 clk = ~clk;

    vscale_htif_host_bridge #(
        .POLL_INTERVAL (POLL),
        .FIFO_DEPTH    (DEPTH),
        .ADDR_TO_HOST  (12'h780),
        .ADDR_FROM_HOST(12'h781)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .fromhost_valid     (fromhost_valid),
        .fromhost_ready     (fromhost_ready),
        .fromhost_data      (fromhost_data),
        .tohost_valid       (tohost_valid),
        .tohost_ready       (tohost_ready),
        .tohost_data        (tohost_data),
        .htif_pcr_req_valid (htif_pcr_req_valid),
        .htif_pcr_req_ready (htif_pcr_req_ready),
        .htif_pcr_req_rw    (htif_pcr_req_rw),
        .htif_pcr_req_addr  (htif_pcr_req_addr),
        .htif_pcr_req_data  (htif_pcr_req_data),
        .htif_pcr_resp_valid(htif_pcr_resp_valid),
        .htif_pcr_resp_ready(htif_pcr_resp_ready),
        .htif_pcr_resp_data (htif_pcr_resp_data),
        .busy               (busy),
        .stat_polls         (stat_polls),
        .stat_msgs          (stat_msgs)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- table vectors ----------------
    typedef struct {
        logic       fv;
        logic [7:0] fd;
        logic       rr;
        logic       rsv;
        logic       efr;
        logic       erv;
        logic [7:0] ed;
        logic       erp;
        logic       ebusy;
    } vec_t;

    vec_t tbl [20];

    function automatic vec_t mk(input int fv, input int fd, input int rr, input int rsv,
                                input int efr, input int erv, input int ed, input int erp,
                                input int ebusy);
        vec_t v;
        v.fv = fv[0]; v.fd = fd[7:0]; v.rr = rr[0]; v.rsv = rsv[0];
        v.efr = efr[0]; v.erv = erv[0]; v.ed = ed[7:0]; v.erp = erp[0]; v.ebusy = ebusy[0];
        return v;
    endfunction

    // ---------------- transaction model state ----------------
    int          mst;            // 0 idle, 1 request outstanding, 2 awaiting response
    logic        m_wr;
    logic [63:0] m_data;
    logic [63:0] wq [$];
    logic        m_thv;
    logic [63:0] m_thd;
    logic [15:0] m_polls;
    logic [15:0] m_msgs;
    int          cyc;
    int          idle_since;
    bit          resp_pend;
    int          resp_cnt;
    logic [63:0] resp_val;
    logic [63:0] csr_q [$];
    int          req_starts [$];
    logic        req_ops [$];
    logic        prev_rv;

    int p_push, p_rrdy, p_thr, lat, rd_zero_pct, push_lo, push_hi;

    task automatic set_knobs(input int pp, input int pr, input int pt, input int l, input int z);
        p_push = pp; p_rrdy = pr; p_thr = pt; lat = l; rd_zero_pct = z;
        push_lo = -1; push_hi = -1;
    endtask

    task automatic model_reset();
        mst = 0; m_wr = 1'b0; m_data = 64'd0; wq.delete();
        m_thv = 1'b0; m_thd = 64'd0; m_polls = 16'd0; m_msgs = 16'd0;
        cyc = 0; idle_since = 0; resp_pend = 0; resp_cnt = 0; resp_val = 64'd0;
        req_starts.delete(); req_ops.delete(); prev_rv = 1'b0;
    endtask

    task automatic reset_dut();
        reset = 1'b1;
        fromhost_valid = 1'b0; tohost_ready = 1'b0;
        htif_pcr_req_ready = 1'b0; htif_pcr_resp_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    function automatic int qat(input int i);
        return (i < req_starts.size()) ? req_starts[i] : -1;
    endfunction

    // One cycle: check outputs against the model, drive inputs, advance the model.
    task automatic step();
        logic        fv, rr, thr, rsv, th_start, forced;
        logic [63:0] fd;
        int          wq_start;

        chk("fromhost_ready", 64'(fromhost_ready), 64'(wq.size() < DEPTH));
        chk("tohost_valid", 64'(tohost_valid), 64'(m_thv));
        if (m_thv) chk("tohost_data", tohost_data, m_thd);
        chk("req_valid", 64'(htif_pcr_req_valid), 64'(mst == 1));
        if (mst == 1) begin
            chk("req_rw", 64'(htif_pcr_req_rw), 64'(m_wr));
            chk("req_addr", 64'(htif_pcr_req_addr), m_wr ? 64'h781 : 64'h780);
            chk("req_data", htif_pcr_req_data, m_data);
        end
        chk("resp_ready", 64'(htif_pcr_resp_ready), 64'(mst == 2));
        chk("busy", 64'(busy), 64'(mst != 0));
`ifdef VSCALE_HTIF_STATS_EN
        chk("stat_polls", 64'(stat_polls), 64'(m_polls));
        chk("stat_msgs", 64'(stat_msgs), 64'(m_msgs));
`else
        chk("stat_polls", 64'(stat_polls), 64'd0);
        chk("stat_msgs", 64'(stat_msgs), 64'd0);
`endif
        if (htif_pcr_req_valid && !prev_rv) begin
            req_starts.push_back(cyc);
            req_ops.push_back(htif_pcr_req_rw);
        end
        prev_rv = htif_pcr_req_valid;

        if (resp_pend && resp_cnt > 0) resp_cnt--;
        rsv = resp_pend && (resp_cnt == 0);
        htif_pcr_resp_valid = rsv;
        htif_pcr_resp_data  = rsv ? resp_val : {$urandom, $urandom};
        rr = ($urandom_range(99) < p_rrdy);
        htif_pcr_req_ready = rr;
        forced = (cyc >= push_lo) && (cyc <= push_hi);
        fv = forced || ($urandom_range(99) < p_push);
        fd = forced ? (64'hB000 + 64'(cyc)) : {$urandom, $urandom};
        fromhost_valid = fv;
        fromhost_data  = fd;
        thr = ($urandom_range(99) < p_thr);
        tohost_ready = thr;

        th_start = m_thv;
        wq_start = wq.size();
        if (m_thv && thr) m_thv = 1'b0;
        case (mst)
            0: begin
                if (wq_start > 0) begin
                    mst = 1; m_wr = 1'b1; m_data = wq[0];
                end else if ((cyc - idle_since >= POLL - 1) && !th_start) begin
                    mst = 1; m_wr = 1'b0; m_data = 64'd0;
                end
            end
            1: begin
                if (rr) begin
                    if (m_wr) begin
                        wq.delete(0);
                        resp_val = {$urandom, $urandom} | 64'd1;
                    end else begin
                        m_polls = m_polls + 16'd1;
                        if (csr_q.size() > 0) resp_val = csr_q.pop_front();
                        else if ($urandom_range(99) < rd_zero_pct) resp_val = 64'd0;
                        else resp_val = {$urandom, $urandom} | 64'd1;
                    end
                    resp_pend = 1; resp_cnt = lat; mst = 2;
                end
            end
            2: begin
                if (rsv) begin
                    resp_pend = 0;
                    if (!m_wr && resp_val != 64'd0) begin
                        m_thv = 1'b1; m_thd = resp_val; m_msgs = m_msgs + 16'd1;
                    end
                    mst = 0; idle_since = cyc + 1;
                end
            end
            default: ;
        endcase
        if (fv && (wq_start < DEPTH)) wq.push_back(fd);
        cyc++;
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic run_table();
        for (int i = 0; i < 20; i++) begin
            fromhost_valid = tbl[i].fv;
            fromhost_data = 64'(tbl[i].fd);
            htif_pcr_req_ready = tbl[i].rr;
            htif_pcr_resp_valid = tbl[i].rsv;
            htif_pcr_resp_data = 64'd0;
            tohost_ready = 1'b0;
            chk($sformatf("tbl%0d_fromhost_ready", i), 64'(fromhost_ready), 64'(tbl[i].efr));
            chk($sformatf("tbl%0d_req_valid", i), 64'(htif_pcr_req_valid), 64'(tbl[i].erv));
            chk($sformatf("tbl%0d_resp_ready", i), 64'(htif_pcr_resp_ready), 64'(tbl[i].erp));
            chk($sformatf("tbl%0d_busy", i), 64'(busy), 64'(tbl[i].ebusy));
            if (tbl[i].erv) begin
                chk($sformatf("tbl%0d_req_rw", i), 64'(htif_pcr_req_rw), 64'd1);
                chk($sformatf("tbl%0d_req_addr", i), 64'(htif_pcr_req_addr), 64'h781);
                chk($sformatf("tbl%0d_req_data", i), htif_pcr_req_data, 64'(tbl[i].ed));
            end
            @(negedge clk);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Write burst against a stalled CSR file: FIFO fills, then drains in order.
        tbl[0]  = mk(1, 'hA0, 0, 0, 1, 0, 'h00, 0, 0);
        tbl[1]  = mk(1, 'hA1, 0, 0, 1, 0, 'h00, 0, 0);
        tbl[2]  = mk(1, 'hA2, 0, 0, 1, 1, 'hA0, 0, 1);
        tbl[3]  = mk(1, 'hA3, 0, 0, 1, 1, 'hA0, 0, 1);
        tbl[4]  = mk(1, 'hA4, 0, 0, 0, 1, 'hA0, 0, 1);
        tbl[5]  = mk(1, 'hA4, 1, 0, 0, 1, 'hA0, 0, 1);
        tbl[6]  = mk(1, 'hA4, 0, 1, 1, 0, 'h00, 1, 1);
        tbl[7]  = mk(0, 'h00, 0, 0, 0, 0, 'h00, 0, 0);
        tbl[8]  = mk(0, 'h00, 1, 0, 0, 1, 'hA1, 0, 1);
        tbl[9]  = mk(0, 'h00, 0, 1, 1, 0, 'h00, 1, 1);
        tbl[10] = mk(0, 'h00, 0, 0, 1, 0, 'h00, 0, 0);
        tbl[11] = mk(0, 'h00, 1, 0, 1, 1, 'hA2, 0, 1);
        tbl[12] = mk(0, 'h00, 0, 1, 1, 0, 'h00, 1, 1);
        tbl[13] = mk(0, 'h00, 0, 0, 1, 0, 'h00, 0, 0);
        tbl[14] = mk(0, 'h00, 1, 0, 1, 1, 'hA3, 0, 1);
        tbl[15] = mk(0, 'h00, 0, 1, 1, 0, 'h00, 1, 1);
        tbl[16] = mk(0, 'h00, 0, 0, 1, 0, 'h00, 0, 0);
        tbl[17] = mk(0, 'h00, 1, 0, 1, 1, 'hA4, 0, 1);
        tbl[18] = mk(0, 'h00, 0, 1, 1, 0, 'h00, 1, 1);
        tbl[19] = mk(0, 'h00, 0, 0, 1, 0, 'h00, 0, 0);

        // Reset values.
        @(negedge clk);
        chk("rst_fromhost_ready", 64'(fromhost_ready), 64'd1);
        chk("rst_tohost_valid", 64'(tohost_valid), 64'd0);
        chk("rst_tohost_data", tohost_data, 64'd0);
        chk("rst_req_valid", 64'(htif_pcr_req_valid), 64'd0);
        chk("rst_req_rw", 64'(htif_pcr_req_rw), 64'd0);
        chk("rst_req_addr", 64'(htif_pcr_req_addr), 64'd0);
        chk("rst_req_data", htif_pcr_req_data, 64'd0);
        chk("rst_resp_ready", 64'(htif_pcr_resp_ready), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_stat_polls", 64'(stat_polls), 64'd0);
        chk("rst_stat_msgs", 64'(stat_msgs), 64'd0);

        reset_dut();
        run_table();

        // Idle polling cadence and statistics: responses 0, 0, 0x55.
        set_knobs(0, 100, 0, 2, 100);
        reset_dut();
        csr_q.delete();
        csr_q.push_back(64'h0); csr_q.push_back(64'h0); csr_q.push_back(64'h55);
        run(80);
        chk("t1_first_poll_cycle", 64'(qat(0)), 64'd16);
        chk("t1_second_poll_cycle", 64'(qat(1)), 64'd35);
        chk("t1_third_poll_cycle", 64'(qat(2)), 64'd54);
        chk("t1_poll_count", 64'(req_starts.size()), 64'd3);
        chk("t6_tohost_data", tohost_data, 64'h55);
`ifdef VSCALE_HTIF_STATS_EN
        chk("t6_stat_polls", 64'(stat_polls), 64'd3);
        chk("t6_stat_msgs", 64'(stat_msgs), 64'd1);
`else
        chk("t6_stat_polls", 64'(stat_polls), 64'd0);
        chk("t6_stat_msgs", 64'(stat_msgs), 64'd0);
`endif

        // Unconsumed message blocks polling; consuming it lets polling resume.
        set_knobs(0, 100, 0, 1, 100);
        reset_dut();
        csr_q.delete();
        csr_q.push_back(64'h1);
        run(130);
        chk("t2_tohost_valid", 64'(tohost_valid), 64'd1);
        chk("t2_tohost_data", tohost_data, 64'h1);
        chk("t2_single_request", 64'(req_starts.size()), 64'd1);
        p_thr = 100;
        run(1);
        p_thr = 0;
        run(40);
        chk("t2_polling_resumed", 64'(req_starts.size() >= 2), 64'd1);

        // Write and due poll in the same cycle: write goes first.
        set_knobs(0, 100, 0, 1, 100);
        reset_dut();
        push_lo = 14; push_hi = 14;
        run(40);
        chk("t4_first_req_cycle", 64'(qat(0)), 64'd16);
        chk("t4_first_req_is_write", 64'((req_ops.size() > 0) && req_ops[0]), 64'd1);
        chk("t4_poll_req_cycle", 64'(qat(1)), 64'd34);
        chk("t4_second_req_is_poll", 64'((req_ops.size() > 1) && !req_ops[1]), 64'd1);

        // Asynchronous reset in the middle of a stalled write request.
        set_knobs(0, 0, 0, 1, 100);
        reset_dut();
        push_lo = 0; push_hi = 2;
        run(5);
        chk("t5_req_valid_before", 64'(htif_pcr_req_valid), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("t5_req_valid", 64'(htif_pcr_req_valid), 64'd0);
        chk("t5_resp_ready", 64'(htif_pcr_resp_ready), 64'd0);
        chk("t5_busy", 64'(busy), 64'd0);
        chk("t5_fromhost_ready", 64'(fromhost_ready), 64'd1);
        chk("t5_tohost_valid", 64'(tohost_valid), 64'd0);
        set_knobs(0, 100, 0, 1, 100);
        reset_dut();
        run(20);
        chk("t5_first_req_after_reset", 64'(qat(0)), 64'd16);
        chk("t5_first_req_is_poll", 64'((req_ops.size() > 0) && !req_ops[0]), 64'd1);

        // Randomised traffic against the model.
        for (int r = 0; r < 6; r++) begin
            set_knobs(int'($urandom_range(60)), int'($urandom_range(20, 100)),
                      int'($urandom_range(100)), int'($urandom_range(1, 3)),
                      int'($urandom_range(30, 90)));
            reset_dut();
            csr_q.delete();
            run(400);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
